pingpong_drain_sched: RTL and testbench
=======================================

# pingpong_drain_sched

Frame-level read scheduler for the ping-pong sample buffer. On each `buffer_ready` pulse it picks one of `NUM_CONSUMERS` requesting consumers by round-robin and grants it the whole frame of `DEPTH` words. While the frame drains, it forwards the buffer's valid/ready/data stream to that consumer only. It sits between the ping-pong buffer read port and the downstream processing blocks (e.g. FFT and logger), and reports completions and overruns.

## Interface
Parameters:
- `WIDTH`, 32, data word width
- `DEPTH`, 16, words per frame; must match the buffer depth
- `NUM_CONSUMERS`, 3, number of requesters (2..8)
- `TIMEOUT`, 1024, stall cycles before abort (only used with the macro)

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; one clock; reset is asynchronous and active-high
- `buffer_ready_i`  in  1  one-cycle pulse: a new frame is readable
- `buf_read_valid_i`  in  1  buffer read valid
- `buf_read_data_i`  in  WIDTH (signed)  buffer read data
- `buf_read_ready_o`  out  1  ready to the buffer
- `req_i`  in  NUM_CONSUMERS  level requests, one bit per consumer
- `cons_ready_i`  in  NUM_CONSUMERS  per-consumer ready
- `grant_o`  out  NUM_CONSUMERS  registered one-hot grant
- `cons_valid_o`  out  NUM_CONSUMERS  per-consumer valid
- `cons_data_o`  out  WIDTH (signed)  shared data bus
- `frame_done_o`  out  1  one-cycle pulse: frame fully drained
- `overrun_o`  out  1  one-cycle pulse: `buffer_ready_i` arrived while busy
- `overrun_count_o`  out  8  saturating overrun counter
- `frame_count_o`  out  8  completed frames, wraps
- `busy_o`  out  1  state is not IDLE
- `timeout_o`  out  1  one-cycle abort pulse; tied 0 without the macro

## Operation
- States:
  - **IDLE**: `buffer_ready_i` → ARB.
  - **ARB**: if `|req_i`, latch the winner into `grant_o` → DRAIN. Otherwise stay in ARB until a request appears.
  - **DRAIN**: a beat is counted when `buf_read_valid_i && buf_read_ready_o`. The beat that brings the count to DEPTH ends the frame → IDLE.
- Round-robin:
  - Search starts at `last_grant + 1` and wraps modulo NUM_CONSUMERS.
  - `last_grant` resets to NUM_CONSUMERS-1, so consumer 0 wins first.
  - `last_grant` updates only when a grant is issued.
- Forwarding (combinational, DRAIN only; all zero otherwise):
  - `cons_valid_o = grant_o & {NUM_CONSUMERS{buf_read_valid_i}}`
  - `buf_read_ready_o = |(grant_o & cons_ready_i)`
  - `cons_data_o = buf_read_data_i` always.
- Beat counter:
  - Width `$clog2(DEPTH)+1`; cleared on entry to DRAIN.
  - Never exceeds DEPTH.
- Frame end:
  - `frame_done_o` pulses and `frame_count_o` increments.
  - `grant_o` clears.
- Overrun: `buffer_ready_i` in ARB or DRAIN:
  - `overrun_o` pulses; `overrun_count_o` increments and saturates at 255.
  - The current frame continues. In ARB, the state is unchanged.
- Simultaneous events:
  - `buffer_ready_i` in the same cycle as the final beat goes to ARB (not IDLE), with no overrun.
  - Requests that drop during DRAIN do not revoke the grant.
- Reset values: all outputs 0, state IDLE, counters 0, `last_grant` = NUM_CONSUMERS-1.
- Reset mid-frame:
  - Grant and valids drop asynchronously.
  - The partial frame is discarded and not counted.

## Timing
- `buffer_ready_i` at cycle T → ARB at T+1.
- With a request present at T+1, `grant_o` is valid and DRAIN starts at T+2.
- Data path latency is zero: consumer valid, data and ready are combinational pass-throughs.
- Final beat at cycle F:
  - `frame_done_o` is high at F+1.
  - `grant_o` = 0 at F+1.
  - `busy_o` = 0 at F+1, unless a new frame was pending.
- `overrun_o` and `timeout_o` are registered and asserted the cycle after the causing event.
- Minimum frame duration is DEPTH beats plus 2 cycles of overhead.

## Configuration
- `PINGPONG_DRAIN_TIMEOUT_EN` defined:
  - A stall counter runs in DRAIN and clears on every beat.
  - When it reaches TIMEOUT, the frame aborts: `timeout_o` pulses, `grant_o` clears, state → IDLE.
  - `frame_done_o` does not pulse and `frame_count_o` is unchanged.
- Undefined:
  - No stall counter; `timeout_o` is constant 0.
  - DRAIN waits indefinitely.

## Test plan
- Reset, then `buffer_ready_i` pulse with `req_i`=3'b011 and all ready:
  - `grant_o`=3'b001 at T+2.
  - 16 beats go to consumer 0.
  - `frame_done_o` fires once; `frame_count_o`=1.
- Three frames with `req_i`=3'b111 → grants in order 001, 010, 100.
- `req_i`=0 for 10 cycles after `buffer_ready_i`:
  - `busy_o`=1 and no valids.
  - Raise `req_i[2]` → `grant_o`=3'b100 on the next cycle.
- `buffer_ready_i` at beat 5 of DRAIN:
  - `overrun_o` pulses and `overrun_count_o`=1.
  - The frame still completes its 16 beats.
- `buffer_ready_i` coincident with the final beat → ARB next cycle, `overrun_count_o` stays 0. Then toggle `cons_ready_i` to check backpressure: beats are counted only on handshake.
- With the macro, TIMEOUT=8: drop `cons_ready_i` mid-frame → `timeout_o` pulses 9 cycles later, state IDLE, `frame_count_o` unchanged. Also assert `rst_i` mid-frame → all outputs 0 immediately.

Source files
------------

// File: rtl/pingpong_drain_sched_if.sv
// Buffer-read stream, consumer fan-out and status signals of pingpong_drain_sched.
// slave is the scheduler side, master is the buffer/consumer/environment side.
interface pingpong_drain_sched_if #(
  parameter int WIDTH         = 32,
  parameter int NUM_CONSUMERS = 3
);
  logic                      buffer_ready_i;
  logic                      buf_read_valid_i;
  logic signed [WIDTH-1:0]   buf_read_data_i;
  logic                      buf_read_ready_o;
  logic [NUM_CONSUMERS-1:0]  req_i;
  logic [NUM_CONSUMERS-1:0]  cons_ready_i;
  logic [NUM_CONSUMERS-1:0]  grant_o;
  logic [NUM_CONSUMERS-1:0]  cons_valid_o;
  logic signed [WIDTH-1:0]   cons_data_o;
  logic                      frame_done_o;
  logic                      overrun_o;
  logic [7:0]                overrun_count_o;
  logic [7:0]                frame_count_o;
  logic                      busy_o;
  logic                      timeout_o;

  modport slave (
    input  buffer_ready_i, buf_read_valid_i, buf_read_data_i, req_i, cons_ready_i,
    output buf_read_ready_o, grant_o, cons_valid_o, cons_data_o, frame_done_o,
           overrun_o, overrun_count_o, frame_count_o, busy_o, timeout_o
  );

  modport master (
    output buffer_ready_i, buf_read_valid_i, buf_read_data_i, req_i, cons_ready_i,
    input  buf_read_ready_o, grant_o, cons_valid_o, cons_data_o, frame_done_o,
           overrun_o, overrun_count_o, frame_count_o, busy_o, timeout_o
  );
endinterface

// File: rtl/pingpong_drain_sched.sv
// Frame-level round-robin read scheduler for the ping-pong sample buffer.
// Optional stall abort enabled by defining PINGPONG_DRAIN_TIMEOUT_EN.
module pingpong_drain_sched #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 16,
  parameter int NUM_CONSUMERS = 3,
  parameter int TIMEOUT       = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  pingpong_drain_sched_if.slave  bus
);
  localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST_IDX   = CW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_CONS  = IW'(NUM_CONSUMERS - 1);

  if (WIDTH < 1 || DEPTH < 1 || NUM_CONSUMERS < 2 || NUM_CONSUMERS > 8 || TIMEOUT < 1) begin : g_cfg_err
    $error("pingpong_drain_sched: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, ARB, DRAIN} state_t;
  state_t state_q, state_d;

  logic [NUM_CONSUMERS-1:0] grant_q;
  logic [IW-1:0]            last_grant_q;
  logic [IW-1:0]            win_idx;
  logic [IW-1:0]            cand;
  logic                     win_found;
  logic [CW-1:0]            beat_cnt_q;
  logic                     frame_done_q;
  logic                     overrun_q;
  logic [7:0]               overrun_cnt_q;
  logic [7:0]               frame_cnt_q;
  logic                     in_drain;
  logic                     beat;
  logic                     last_beat;
  logic                     grant_ev;
  logic                     overrun_ev;
  logic                     abort;

  // Round-robin search starting one past the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_grant_q;
    cand      = last_grant_q;
    for (int i = 1; i <= NUM_CONSUMERS; i++) begin
      cand = IW'((int'(last_grant_q) + i) % NUM_CONSUMERS);
      if (!win_found && bus.req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign in_drain  = (state_q == DRAIN);
  assign grant_ev  = (state_q == ARB) && win_found;
  assign beat      = in_drain && bus.buf_read_valid_i && bus.buf_read_ready_o;
  assign last_beat = beat && (beat_cnt_q == LAST_IDX);
  // A new frame landing on the final beat is just the next frame, not an overrun.
  assign overrun_ev = bus.buffer_ready_i && ((state_q == ARB) || (in_drain && !last_beat));

  // Zero-latency forwarding, gated so nothing leaks outside DRAIN.
  assign bus.cons_valid_o     = in_drain ? (grant_q & {NUM_CONSUMERS{bus.buf_read_valid_i}}) : '0;
  assign bus.buf_read_ready_o = in_drain && (|(grant_q & bus.cons_ready_i));
  assign bus.cons_data_o      = bus.buf_read_data_i;

`ifdef PINGPONG_DRAIN_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT);
  logic [SW-1:0] stall_q;
  logic          timeout_q;

  assign abort = in_drain && !beat && (stall_q == STALL_MAX);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= abort;
      if (!in_drain || beat)      stall_q <= '0;
      else if (stall_q != STALL_MAX) stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  assign abort         = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.buffer_ready_i) state_d = ARB;
      ARB:     if (win_found)          state_d = DRAIN;
      DRAIN: begin
        if (last_beat)  state_d = bus.buffer_ready_i ? ARB : IDLE;
        else if (abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_q       <= '0;
      last_grant_q  <= LAST_CONS;
      beat_cnt_q    <= '0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      overrun_cnt_q <= '0;
      frame_cnt_q   <= '0;
    end else begin
      frame_done_q <= last_beat;
      overrun_q    <= overrun_ev;

      if (grant_ev) begin
        grant_q      <= NUM_CONSUMERS'(1) << win_idx;
        last_grant_q <= win_idx;
      end else if (last_beat || abort) begin
        grant_q <= '0;
      end

      if (grant_ev)  beat_cnt_q <= '0;
      else if (beat) beat_cnt_q <= beat_cnt_q + 1'b1;

      if (last_beat) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (overrun_ev && overrun_cnt_q != 8'hFF) overrun_cnt_q <= overrun_cnt_q + 1'b1;
    end
  end

  assign bus.grant_o         = grant_q;
  assign bus.frame_done_o    = frame_done_q;
  assign bus.overrun_o       = overrun_q;
  assign bus.overrun_count_o = overrun_cnt_q;
  assign bus.frame_count_o   = frame_cnt_q;
  assign bus.busy_o          = (state_q != IDLE);
endmodule

// File: tb/tb_pingpong_drain_sched.sv
// Bench for pingpong_drain_sched: arbitration table, scoreboarded beat stream,
// and hand-written overrun / backpressure / reset / timeout sequences.
module tb_pingpong_drain_sched;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 16;
  localparam int NC      = 3;
  localparam int TIMEOUT = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   ov_pulses = 0;

  typedef struct packed { logic [1:0] cons; logic [WIDTH-1:0] data; } sb_t;
  sb_t sb[$];
  sb_t mon_e;

  typedef struct { logic [2:0] req; logic [2:0] g; } arb_vec_t;
  arb_vec_t vecs[10];

  pingpong_drain_sched_if #(.WIDTH(WIDTH), .NUM_CONSUMERS(NC)) bus();

  pingpong_drain_sched #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CONSUMERS(NC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Every accepted beat must match the oldest outstanding expected word.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (bus.overrun_o) ov_pulses++;
      for (int c = 0; c < NC; c++) begin
        if (bus.cons_valid_o[c] && bus.cons_ready_i[c]) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_underflow actual=beat_on_%0d required=no_beat t=%0t", c, $time);
          end else begin
            mon_e = sb.pop_front();
            chk("beat_cons", 64'(c), 64'(mon_e.cons));
            chk("beat_data", 64'($unsigned(bus.cons_data_o)), 64'(mon_e.data));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    bus.buffer_ready_i = 1'b0; bus.buf_read_valid_i = 1'b0;
    bus.req_i = '0; bus.cons_ready_i = '1;
    tick(); tick();
    sb.delete();
    rst_i = 1'b0;
  endtask

  task automatic start_frame();
    bus.buffer_ready_i = 1'b1;
    tick();
    bus.buffer_ready_i = 1'b0;
  endtask

  // Streams DEPTH words to the granted consumer; optional buffer_ready on word br_at
  // and optional toggling ready on the granted consumer.
  task automatic send_frame(input int cons, input int br_at, input bit bp);
    sb_t e;
    bit  hs;
    int  guard;
    int  cyc = 0;
    for (int b = 0; b < DEPTH; b++) begin
      bus.buf_read_valid_i = 1'b1;
      bus.buf_read_data_i  = $urandom;
      e.cons = 2'(cons); e.data = bus.buf_read_data_i;
      sb.push_back(e);
      bus.buffer_ready_i = (b == br_at);
      guard = 0;
      hs    = 1'b0;
      while (!hs && guard < 50) begin
        if (bp) bus.cons_ready_i[2'(cons)] = cyc[0];
        cyc++;
        @(negedge clk_i);
        chk("fwd_valid", bus.cons_valid_o, 64'(3'b001 << cons));
        if (bp) chk("bp_ready", bus.buf_read_ready_o, bus.cons_ready_i[2'(cons)]);
        hs = bus.buf_read_ready_o;
        tick();
        bus.buffer_ready_i = 1'b0;
        guard++;
      end
      if (!hs) begin
        total++; bad++;
        $display("FAIL handshake_wait actual=no_ready required=ready beat=%0d", b);
      end
    end
    bus.buf_read_valid_i = 1'b0;
    bus.cons_ready_i     = '1;
  endtask

  task automatic chk_frame_end(input int exp_fc, input bit exp_busy);
    chk("frame_done", bus.frame_done_o, 1);
    chk("grant_clear", bus.grant_o, 0);
    chk("frame_count", bus.frame_count_o, 64'(exp_fc));
    chk("busy_end", bus.busy_o, 64'(exp_busy));
    tick();
    chk("done_pulse", bus.frame_done_o, 0);
  endtask

  task automatic arb_frame(input logic [2:0] req, input logic [2:0] exp_g, input int exp_fc,
                           input int br_at, input bit bp, input bit exp_busy);
    int cons;
    cons = exp_g[2] ? 2 : (exp_g[1] ? 1 : 0);
    bus.req_i = req;
    start_frame();
    chk("arb_busy", bus.busy_o, 1);
    chk("arb_no_grant", bus.grant_o, 0);
    tick();
    chk("grant", bus.grant_o, 64'(exp_g));
    send_frame(cons, br_at, bp);
    chk_frame_end(exp_fc, exp_busy);
  endtask

  initial begin
    vecs[0] = '{3'b111, 3'b001}; vecs[1] = '{3'b111, 3'b010};
    vecs[2] = '{3'b111, 3'b100}; vecs[3] = '{3'b101, 3'b001};
    vecs[4] = '{3'b110, 3'b010}; vecs[5] = '{3'b100, 3'b100};
    vecs[6] = '{3'b011, 3'b001}; vecs[7] = '{3'b100, 3'b100};
    vecs[8] = '{3'b001, 3'b001}; vecs[9] = '{3'b010, 3'b010};

    bus.buffer_ready_i = 1'b0; bus.buf_read_valid_i = 1'b0; bus.buf_read_data_i = '0;
    bus.req_i = '0; bus.cons_ready_i = '1;
    rst_i = 1'b1;
    tick(); tick();
    chk("rst_grant", bus.grant_o, 0);
    chk("rst_valid", bus.cons_valid_o, 0);
    chk("rst_ready", bus.buf_read_ready_o, 0);
    chk("rst_done", bus.frame_done_o, 0);
    chk("rst_overrun", bus.overrun_o, 0);
    chk("rst_ovcnt", bus.overrun_count_o, 0);
    chk("rst_fcnt", bus.frame_count_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_timeout", bus.timeout_o, 0);
    rst_i = 1'b0;

    // First frame after reset goes to consumer 0.
    arb_frame(3'b011, 3'b001, 1, -1, 1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < 10; i++) arb_frame(vecs[i].req, vecs[i].g, i + 1, -1, 1'b0, 1'b0);

    // No requesters: stay in ARB with everything quiet, then a late request wins.
    bus.req_i = '0;
    bus.buf_read_valid_i = 1'b1;
    start_frame();
    for (int i = 0; i < 10; i++) begin
      chk("wait_busy", bus.busy_o, 1);
      chk("wait_valid", bus.cons_valid_o, 0);
      chk("wait_grant", bus.grant_o, 0);
      tick();
    end
    bus.buf_read_valid_i = 1'b0;
    bus.req_i = 3'b100;
    tick();
    chk("late_grant", bus.grant_o, 3'b100);
    send_frame(2, -1, 1'b0);
    chk_frame_end(11, 1'b0);

    // Overrun mid-frame: pulses once, frame still completes.
    ov_pulses = 0;
    arb_frame(3'b111, 3'b001, 12, 5, 1'b0, 1'b0);
    chk("ov_pulses", 64'(ov_pulses), 1);
    chk("ov_count", bus.overrun_count_o, 1);

    // buffer_ready on the final beat chains straight into ARB, then backpressure.
    do_reset();
    ov_pulses = 0;
    arb_frame(3'b111, 3'b001, 1, DEPTH - 1, 1'b0, 1'b1);
    chk("chain_grant", bus.grant_o, 3'b010);
    send_frame(1, -1, 1'b1);
    chk_frame_end(2, 1'b0);
    chk("chain_ov_pulses", 64'(ov_pulses), 0);
    chk("chain_ov_count", bus.overrun_count_o, 0);

    // Reset mid-frame drops grant and valids at once.
    bus.req_i = 3'b111;
    start_frame();
    tick();
    for (int k = 0; k < 3; k++) begin
      sb_t e;
      bus.buf_read_valid_i = 1'b1;
      bus.buf_read_data_i  = $urandom;
      e.cons = 2'd2; e.data = bus.buf_read_data_i;
      sb.push_back(e);
      tick();
    end
    rst_i = 1'b1;
    #1;
    chk("mid_rst_grant", bus.grant_o, 0);
    chk("mid_rst_valid", bus.cons_valid_o, 0);
    chk("mid_rst_busy", bus.busy_o, 0);
    chk("mid_rst_ready", bus.buf_read_ready_o, 0);
    chk("mid_rst_sb", 64'(sb.size()), 0);
    bus.buf_read_valid_i = 1'b0;
    tick();
    rst_i = 1'b0;
    chk("mid_rst_fcnt", bus.frame_count_o, 0);

`ifdef PINGPONG_DRAIN_TIMEOUT_EN
    begin
      int k;
      do_reset();
      bus.req_i = 3'b111;
      start_frame();
      tick();
      for (int b = 0; b < 2; b++) begin
        sb_t e;
        bus.buf_read_valid_i = 1'b1;
        bus.buf_read_data_i  = $urandom;
        e.cons = 2'd0; e.data = bus.buf_read_data_i;
        sb.push_back(e);
        tick();
      end
      bus.cons_ready_i = '0;
      bus.buf_read_data_i = $urandom;
      k = 0;
      while (k < 30) begin
        @(negedge clk_i);
        if (bus.timeout_o) break;
        k++;
      end
      chk("timeout_latency", 64'(k), 9);
      chk("timeout_busy", bus.busy_o, 0);
      chk("timeout_grant", bus.grant_o, 0);
      chk("timeout_done", bus.frame_done_o, 0);
      chk("timeout_fcnt", bus.frame_count_o, 0);
      bus.buf_read_valid_i = 1'b0;
      bus.cons_ready_i = '1;
      sb.delete();
      tick();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
